// File: rtl/riscv_ex_wb_queue.sv
// EX-to-WB result queue: selects one functional-unit result and enqueues the
// register-file write into a DEPTH-entry in-order queue with forwarding lookups.
module riscv_ex_wb_queue #(
  parameter int unsigned NUM_UNITS  = 2,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DEPTH      = 2,
  parameter int unsigned NUM_RPORTS = 2
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             instr_valid_i,
  input  logic [NUM_UNITS-1:0]             unit_sel_i,
  input  logic [NUM_UNITS*DATA_WIDTH-1:0]  unit_result_i,
  input  logic [NUM_UNITS-1:0]             unit_ready_i,
  input  logic                             lsu_ready_ex_i,
  input  logic                             branch_in_ex_i,
  input  logic                             regfile_we_i,
  input  logic [ADDR_WIDTH-1:0]            regfile_waddr_i,
  input  logic                             flush_i,
  output logic                             ex_ready_o,
  output logic                             ex_valid_o,
  output logic                             wb_valid_o,
  output logic [ADDR_WIDTH-1:0]            wb_waddr_o,
  output logic [DATA_WIDTH-1:0]            wb_wdata_o,
  input  logic                             wb_ready_i,
  input  logic [NUM_RPORTS*ADDR_WIDTH-1:0] fw_raddr_i,
  output logic [NUM_RPORTS-1:0]            fw_hit_o,
  output logic [NUM_RPORTS*DATA_WIDTH-1:0] fw_rdata_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q [DEPTH];
  logic [DATA_WIDTH-1:0] data_q [DEPTH];

  logic [DATA_WIDTH-1:0] res_data;
  logic                  units_done;
  logic                  pop, push, space;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (int'(p) == int'(DEPTH) - 1) return '0;
    return p + 1'b1;
  endfunction

  // Descending scan so the lowest selected unit wins.
  always_comb begin
    res_data   = '0;
    units_done = lsu_ready_ex_i;
    for (int k = int'(NUM_UNITS) - 1; k >= 0; k--) begin
      if (unit_sel_i[k]) begin
        res_data = unit_result_i[k*DATA_WIDTH +: DATA_WIDTH];
        if (!unit_ready_i[k]) units_done = 1'b0;
      end
    end
  end

  assign wb_valid_o = (cnt_q != '0);
  assign pop        = wb_valid_o & wb_ready_i;
  assign space      = (cnt_q < CW'(DEPTH)) | pop;
  assign ex_valid_o = instr_valid_i & units_done & space & ~flush_i;
  assign ex_ready_o = ex_valid_o | branch_in_ex_i;
  assign push       = ex_valid_o & regfile_we_i;

  assign wb_waddr_o = addr_q[rd_ptr_q];
  assign wb_wdata_o = data_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      if (push && !pop)      cnt_d = cnt_q + CW'(1);
      else if (pop && !push) cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      if (push && !flush_i) begin
        addr_q[wr_ptr_q] <= regfile_waddr_i;
        data_q[wr_ptr_q] <= res_data;
      end
    end
  end

  // Walk oldest to youngest so the last match seen is the youngest pending write.
  always_comb begin
    fw_hit_o   = '0;
    fw_rdata_o = '0;
    for (int p = 0; p < int'(NUM_RPORTS); p++) begin
      logic                  hit;
      logic [DATA_WIDTH-1:0] dat;
      logic [ADDR_WIDTH-1:0] ra;
      int                    idx;
      hit = 1'b0;
      dat = '0;
      ra  = fw_raddr_i[p*ADDR_WIDTH +: ADDR_WIDTH];
      for (int i = 0; i < int'(DEPTH); i++) begin
        idx = int'(rd_ptr_q) + i;
        if (idx >= int'(DEPTH)) idx = idx - int'(DEPTH);
        if ((i < int'(cnt_q)) && (addr_q[PW'(idx)] == ra)) begin
          hit = 1'b1;
          dat = data_q[PW'(idx)];
        end
      end
      if (ra == '0) hit = 1'b0;
      fw_hit_o[p] = hit;
      fw_rdata_o[p*DATA_WIDTH +: DATA_WIDTH] = hit ? dat : '0;
    end
  end

endmodule

// File: tb/tb_riscv_ex_wb_queue.sv
// Self-checking bench for riscv_ex_wb_queue: directed steps plus random traffic
// against a queue-based reference model.
module tb_riscv_ex_wb_queue;
  localparam int NU = 2;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int D  = 2;
  localparam int NR = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              instr_valid;
  logic [NU-1:0]     unit_sel, unit_ready;
  logic [NU*DW-1:0]  unit_result;
  logic              lsu_ready, branch, we, flush, wb_ready;
  logic [AW-1:0]     waddr;
  logic [NR*AW-1:0]  fw_raddr;
  logic              ex_ready, ex_valid, wb_valid;
  logic [AW-1:0]     wb_waddr;
  logic [DW-1:0]     wb_wdata;
  logic [NR-1:0]     fw_hit;
  logic [NR*DW-1:0]  fw_rdata;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ent_t;
  ent_t q[$];

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  riscv_ex_wb_queue #(
    .NUM_UNITS(NU), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(D), .NUM_RPORTS(NR)
  ) dut (
    .clk(clk), .rst_n(rst_n), .instr_valid_i(instr_valid), .unit_sel_i(unit_sel),
    .unit_result_i(unit_result), .unit_ready_i(unit_ready), .lsu_ready_ex_i(lsu_ready),
    .branch_in_ex_i(branch), .regfile_we_i(we), .regfile_waddr_i(waddr), .flush_i(flush),
    .ex_ready_o(ex_ready), .ex_valid_o(ex_valid), .wb_valid_o(wb_valid),
    .wb_waddr_o(wb_waddr), .wb_wdata_o(wb_wdata), .wb_ready_i(wb_ready),
    .fw_raddr_i(fw_raddr), .fw_hit_o(fw_hit), .fw_rdata_o(fw_rdata)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_wb_valid"}, 64'(wb_valid), 64'd0);
    chk({tag, "_wb_waddr"}, 64'(wb_waddr), 64'd0);
    chk({tag, "_wb_wdata"}, 64'(wb_wdata), 64'd0);
    chk({tag, "_fw_hit"},   64'(fw_hit),   64'd0);
    chk({tag, "_fw_rdata"}, 64'(fw_rdata), 64'd0);
  endtask

  // One clock: check combinational outputs against the model, clock, update model.
  task automatic cyc();
    logic          done, space, exv, found;
    logic [DW-1:0] dat, fdat;
    logic [AW-1:0] ra;
    #1;
    done = lsu_ready;
    dat  = '0;
    for (int k = 0; k < NU; k++)
      if (unit_sel[k] && !unit_ready[k]) done = 1'b0;
    for (int k = 0; k < NU; k++)
      if (unit_sel[k]) begin
        dat = unit_result[k*DW +: DW];
        break;
      end
    space = (q.size() < D) || (q.size() > 0 && wb_ready);
    exv   = instr_valid && done && space && !flush;
    chk("ex_valid", 64'(ex_valid), 64'(exv));
    chk("ex_ready", 64'(ex_ready), 64'(exv || branch));
    chk("wb_valid", 64'(wb_valid), 64'(q.size() != 0));
    if (q.size() != 0) begin
      chk("wb_waddr", 64'(wb_waddr), 64'(q[0].a));
      chk("wb_wdata", 64'(wb_wdata), 64'(q[0].d));
    end
    for (int p = 0; p < NR; p++) begin
      ra    = fw_raddr[p*AW +: AW];
      found = 1'b0;
      fdat  = '0;
      for (int j = q.size() - 1; j >= 0; j--)
        if (q[j].a == ra) begin
          found = 1'b1;
          fdat  = q[j].d;
          break;
        end
      if (ra == 0) found = 1'b0;
      chk("fw_hit",   64'(fw_hit[p]), 64'(found));
      chk("fw_rdata", 64'(fw_rdata[p*DW +: DW]), found ? 64'(fdat) : 64'd0);
    end
    @(posedge clk);
    if (flush) q.delete();
    else begin
      if (q.size() > 0 && wb_ready) void'(q.pop_front());
      if (exv && we) q.push_back('{a: waddr, d: dat});
    end
    #1;
  endtask

  task automatic set_push(input logic [AW-1:0] a, input logic [DW-1:0] d0);
    instr_valid = 1'b1;
    we          = 1'b1;
    waddr       = a;
    unit_sel    = 2'b01;
    unit_ready  = 2'b11;
    unit_result = {32'hdead_beef, d0};
  endtask

  initial begin
    rst_n = 1'b0; instr_valid = 0; unit_sel = 0; unit_ready = 0; unit_result = 0;
    lsu_ready = 1; branch = 0; we = 0; flush = 0; wb_ready = 0; waddr = 0;
    fw_raddr = {5'd0, 5'd5};
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    cyc();

    // fill: x5=0x11, x6=0x22, then a third push stalls
    set_push(5'd5, 32'h11); cyc();
    set_push(5'd6, 32'h22); cyc();
    chk("full_head_addr", 64'(wb_waddr), 64'd5);
    chk("full_head_data", 64'(wb_wdata), 64'h11);
    set_push(5'd7, 32'h33);
    #1 chk("full_stall", 64'(ex_valid), 64'd0);
    branch = 1'b1; cyc(); branch = 1'b0;

    // push+pop while full, then drain
    wb_ready = 1'b1; cyc();
    chk("pp_head_addr", 64'(wb_waddr), 64'd6);
    instr_valid = 1'b0; cyc();
    chk("pp_head2_addr", 64'(wb_waddr), 64'd7);
    chk("pp_head2_data", 64'(wb_wdata), 64'h33);
    cyc(); cyc();

    // forwarding: two pending writes to x5, lookup ports 5 and 0
    wb_ready = 1'b0;
    set_push(5'd5, 32'h11); cyc();
    set_push(5'd5, 32'h55); cyc();
    instr_valid = 1'b0;
    #1;
    chk("fw_hit_vec", 64'(fw_hit), 64'b01);
    chk("fw_rdata0",  64'(fw_rdata[DW-1:0]), 64'h55);
    wb_ready = 1'b1; cyc(); cyc(); cyc();

    // unit readiness gating: unit 1 selected but not done
    wb_ready = 1'b0;
    set_push(5'd9, 32'h0); unit_sel = 2'b10; unit_ready = 2'b01;
    unit_result = {32'hcafe_0001, 32'h0bad_0bad};
    cyc();
    unit_ready = 2'b11; cyc();
    chk("unit1_data", 64'(wb_wdata), 64'hcafe_0001);

    // flush on a full queue with a push attempt
    set_push(5'd10, 32'hAA); cyc();
    set_push(5'd11, 32'hBB); flush = 1'b1; cyc(); flush = 1'b0;
    instr_valid = 1'b0; cyc();

    // random traffic
    for (int n = 0; n < 400; n++) begin
      instr_valid = 1'($urandom_range(0, 3) != 0);
      unit_sel    = 2'($urandom_range(0, 3));
      unit_ready  = 2'($urandom_range(0, 3) | (($urandom_range(0, 1) != 0) ? 2'b11 : 2'b00));
      unit_result = {$urandom(), $urandom()};
      lsu_ready   = 1'($urandom_range(0, 7) != 0);
      branch      = 1'($urandom_range(0, 7) == 0);
      we          = 1'($urandom_range(0, 4) != 0);
      waddr       = 5'($urandom_range(0, 7));
      flush       = 1'($urandom_range(0, 31) == 0);
      wb_ready    = 1'($urandom_range(0, 2) != 0);
      fw_raddr    = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      cyc();
    end

    // async reset mid-stream, with pending entries
    flush = 1'b0; wb_ready = 1'b0; lsu_ready = 1'b1; branch = 1'b0;
    set_push(5'd3, 32'h77); fw_raddr = {5'd0, 5'd3}; cyc();
    set_push(5'd4, 32'h88); fw_raddr = {5'd3, 5'd4}; cyc();
    instr_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs("async_rst");
    q.delete();
    #1 rst_n = 1'b1;
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/riscv_ex_wb_queue.md
# riscv_ex_wb_queue

Parametrised execute-to-writeback result stage for the RI5CY core. Selects one of `NUM_UNITS` functional-unit results and enqueues the register-file write into a `DEPTH`-entry in-order queue instead of a single EX/WB register. EX can therefore retire while WB is stalled. Pending writes are exposed to ID through `NUM_RPORTS` forwarding lookups. The block sits between the functional units (ALU, multiplier, CSR path) and the WB stage / register-file write port.

## Interface
Parameters:
- `NUM_UNITS`, 2: number of functional-unit result inputs (≥1)
- `DATA_WIDTH`, 32: result width
- `ADDR_WIDTH`, 5: register address width
- `DEPTH`, 2: queue entries (≥1; any integer, not restricted to powers of two)
- `NUM_RPORTS`, 2: forwarding lookup ports

Ports:
- `clk`  in  1  core clock
- `rst_n`  in  1  asynchronous, active-low reset
- `instr_valid_i`  in  1  instruction present in EX
- `unit_sel_i`  in  NUM_UNITS  one-hot result source select
- `unit_result_i`  in  NUM_UNITS*DATA_WIDTH  results, unit k at bits [k*DATA_WIDTH +: DATA_WIDTH]
- `unit_ready_i`  in  NUM_UNITS  per-unit done
- `lsu_ready_ex_i`  in  1  EX part of LSU done
- `branch_in_ex_i`  in  1  branch in EX (completes without WB)
- `regfile_we_i`  in  1  instruction writes the register file
- `regfile_waddr_i`  in  ADDR_WIDTH  destination register
- `flush_i`  in  1  synchronous queue flush (exception/debug)
- `ex_ready_o`  out  1  EX ready for new instruction
- `ex_valid_o`  out  1  EX completes instruction this cycle
- `wb_valid_o`  out  1  head entry valid
- `wb_waddr_o`  out  ADDR_WIDTH  head destination
- `wb_wdata_o`  out  DATA_WIDTH  head data
- `wb_ready_i`  in  1  WB accepts head this cycle
- `fw_raddr_i`  in  NUM_RPORTS*ADDR_WIDTH  lookup addresses
- `fw_hit_o`  out  NUM_RPORTS  pending write matches
- `fw_rdata_o`  out  NUM_RPORTS*DATA_WIDTH  youngest matching data

## Operation
- Result mux: data = `unit_result_i` slice of the lowest set bit of `unit_sel_i`. If `unit_sel_i` is all zero, data = 0.
- `pop` = `wb_valid_o & wb_ready_i`.
- `space` = (count < DEPTH) | `pop`.
- `units_done` = AND of `unit_ready_i` over the bits set in `unit_sel_i` (1 if none set), AND `lsu_ready_ex_i`.
- `ex_valid_o` = `instr_valid_i & units_done & space & ~flush_i`.
- `ex_ready_o` = `ex_valid_o | branch_in_ex_i`.
- `push` = `ex_valid_o & regfile_we_i`. Non-writing instructions complete without allocating an entry.
- Storage is circular: write pointer, read pointer, and count of width clog2(DEPTH+1). Pointers wrap from DEPTH-1 to 0.
- Simultaneous push and pop when full is legal: count stays DEPTH and both pointers advance.
- Simultaneous push and pop when count==1: head advances to the new entry and count stays 1.
- `flush_i` has priority over push and pop. Next cycle: count=0, pointers=0, `wb_valid_o`=0. No push occurs in the flush cycle.
- `wb_valid_o` = (count != 0). `wb_waddr_o`/`wb_wdata_o` reflect the head entry. Their value when count==0 is don't-care but must be stable (no X).
- Forwarding, per port p:
  - Compare `fw_raddr_i[p]` against all valid entries.
  - `fw_hit_o[p]`=1 if any entry matches and the address ≠ 0.
  - `fw_rdata_o[p]` = youngest matching entry's data, else 0.
  - Combinational from queue state only. The entry being pushed in the same cycle is not visible.
- Register x0 writes are queued normally; WB discards them.

## Timing
- Reset (async, `rst_n`=0): count=0, pointers=0, all entry valid/we state cleared. Outputs: `wb_valid_o`=0, `wb_waddr_o`=0, `wb_wdata_o`=0, `fw_hit_o`=0, `fw_rdata_o`=0. Entry storage reset to 0.
- Reset asserted mid-operation discards all pending entries immediately.
- Push latency: entry pushed at edge N appears at `wb_*` (if the queue was empty) and in forwarding from cycle N+1.
- `ex_ready_o`, `ex_valid_o` are combinational from inputs and count. There is no combinational path from `wb_ready_i` to them other than through `space`.
- Full queue with `wb_ready_i`=0: `ex_valid_o`=0 and EX stalls. A branch still gives `ex_ready_o`=1.
- Throughput: one push and one pop per cycle sustained at any DEPTH ≥1.

## Test plan
- Reset, then with DEPTH=2: push x5=0x11, x6=0x22 with `wb_ready_i`=0. Expect count=2, `wb_valid_o`=1, `wb_waddr_o`=5, `wb_wdata_o`=0x11. A third push gives `ex_valid_o`=0.
- Full queue, assert `wb_ready_i`=1 while pushing x7=0x33. Expect `ex_valid_o`=1 and heads 6/0x22 then 7/0x33 on the next two cycles. Pointer wrap is exercised.
- Pending x5=0x11 (older) and x5=0x55 (younger), lookup 5 and 0. Expect `fw_hit_o`=2'b01 and `fw_rdata_o[0]`=0x55.
- `unit_sel_i`=2'b10, `unit_ready_i`=2'b01. Expect `ex_valid_o`=0. When `unit_ready_i`=2'b11, the entry data equals unit 1's result.
- `flush_i`=1 with a full queue plus a push attempt. Expect `ex_valid_o`=0 and `wb_valid_o`=0 the next cycle.
- Async `rst_n` pulse mid-stream: all outputs return to 0 without waiting for a clock edge.
